// File: rtl/aes_pkg.sv
// Shared AES types, sizes and GF(2^8) helpers.
// Imported by the key schedule and the cipher controllers.
package aes_pkg;

  localparam int AES_KEY_LENGTH = 256;
  localparam int AES_BLOCK_SIZE = 128;
  localparam int AES_WORD_SIZE = 32;
  localparam int AES_NUMBER_OF_ROUNDS = 14;
  localparam int AES_NUMBER_OF_ROUND_KEYS = 15;
  localparam int AES_ROUND_KEY_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_DONE
  } aes_ks_state_e;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as x^254 (field inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] r;
    y = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// One AES-256 key expansion step: derives round key
// Round_number from the previous 256-bit window.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic [AES_ROUND_KEY_INDEX_WIDTH-1:0] Round_number,
  input  logic [AES_KEY_LENGTH-1:0]            Input_key,
  output logic [AES_BLOCK_SIZE-1:0]            Output_key
);

  logic [AES_WORD_SIZE-1:0] w0, w1, w2, w3, w7;
  logic [AES_WORD_SIZE-1:0] t;
  logic [AES_WORD_SIZE-1:0] o0, o1, o2, o3;
  logic [7:0]               rcon;

  assign w0 = Input_key[255:224];
  assign w1 = Input_key[223:192];
  assign w2 = Input_key[191:160];
  assign w3 = Input_key[159:128];
  assign w7 = Input_key[31:0];

  assign rcon = 8'h01 << (Round_number[3:1] - 3'd1);

  // Even rounds start a new 8-word block (RotWord + Rcon),
  // odd rounds only apply SubWord.
  always_comb begin
    t = sub_word(w7);
    if (!Round_number[0]) begin
      t = sub_word({w7[23:0], w7[31:24]}) ^ {rcon, 24'h0};
    end
  end

  assign o0 = w0 ^ t;
  assign o1 = w1 ^ o0;
  assign o2 = w2 ^ o1;
  assign o3 = w3 ^ o2;

  assign Output_key = {o0, o1, o2, o3};

endmodule

// File: rtl/aes_key_schedule.sv
// AES-256 key schedule: expands one round key per clock
// and serves all 15 round keys by index.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 Key_valid,
  output logic                                 Key_ready,
  input  logic [AES_KEY_LENGTH-1:0]            Cipher_key,
  output logic                                 Busy,
  output logic                                 Keys_valid,
  input  logic [AES_ROUND_KEY_INDEX_WIDTH-1:0] Rk_index,
  output logic [AES_BLOCK_SIZE-1:0]            Round_key
);

  localparam logic [AES_ROUND_KEY_INDEX_WIDTH-1:0] LAST_RK =
    AES_ROUND_KEY_INDEX_WIDTH'(AES_NUMBER_OF_ROUNDS);
  localparam logic [AES_ROUND_KEY_INDEX_WIDTH-1:0] FIRST_RK =
    AES_ROUND_KEY_INDEX_WIDTH'(2);

  aes_ks_state_e state_q, state_d;

  logic [AES_ROUND_KEY_INDEX_WIDTH-1:0] counter_q;
  logic [AES_KEY_LENGTH-1:0]            window_q;
  logic [AES_BLOCK_SIZE-1:0]            next_key;
  logic [AES_BLOCK_SIZE-1:0]            round_key_q;
  logic [AES_BLOCK_SIZE-1:0]            rk_q [AES_NUMBER_OF_ROUND_KEYS];
  logic                                 load;
  logic                                 step;

  aes_key_expansion u_expand (
    .Round_number (counter_q),
    .Input_key    (window_q),
    .Output_key   (next_key)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      KS_IDLE, KS_DONE: begin
        if (Key_valid && !Rst) begin
          load    = 1'b1;
          state_d = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        step = !Rst;
        if (counter_q == LAST_RK) state_d = KS_DONE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= KS_IDLE;
      counter_q   <= FIRST_RK;
      round_key_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        counter_q <= FIRST_RK;
      end else if (step && counter_q != LAST_RK) begin
        counter_q <= counter_q + 1'b1;
      end
      // Uses the pre-edge Keys_valid, so a read racing a new
      // key still returns the previous schedule.
      if (Keys_valid && Rk_index <= LAST_RK) begin
        round_key_q <= rk_q[Rk_index];
      end else begin
        round_key_q <= '0;
      end
    end
  end

  // Storage and window are intentionally not cleared by reset.
  always_ff @(posedge Clk) begin
    if (load) begin
      window_q <= Cipher_key;
      rk_q[0]  <= Cipher_key[255:128];
      rk_q[1]  <= Cipher_key[127:0];
    end else if (step) begin
      window_q         <= {window_q[127:0], next_key};
      rk_q[counter_q]  <= next_key;
    end
  end

  assign Key_ready  = (state_q != KS_EXPAND);
  assign Busy       = (state_q == KS_EXPAND);
  assign Keys_valid = (state_q == KS_DONE);
  assign Round_key  = round_key_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Sequential AES-256 key schedule controller. It accepts a 256-bit cipher key over a valid/ready handshake and iterates the existing combinational aes_key_expansion stage one round per clock. It stores all 15 round keys in an internal register file and serves them by index to the downstream cipher/decipher round datapath. Random access by index lets encryption (0→14) and decryption (14→0) share the same schedule.

Parameters:
None. All sizes come from aes_defines.svh: AES_KEY_LENGTH=256, AES_BLOCK_SIZE=128, AES_WORD_SIZE=32, AES_NUMBER_OF_ROUNDS=14.

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  synchronous, active-high reset
Key_valid  input  1  Cipher_key is valid this cycle
Key_ready  output  1  block can accept a new key (high in IDLE and DONE)
Cipher_key  input  AES_KEY_LENGTH  256-bit key; words laid out per AES_1ST..AES_8TH_WORD
Busy  output  1  expansion in progress
Keys_valid  output  1  all 15 round keys are stored and readable
Rk_index  input  4  round key index, 0..14
Round_key  output  AES_BLOCK_SIZE  registered read data for Rk_index

Behaviour:
- Reset (Rst=1 at a rising edge): state=IDLE; Key_ready=1, Busy=0, Keys_valid=0, Round_key=0, round counter=2.
  - Round key storage is not cleared.
  - Reset mid-expansion aborts the expansion; a key must be reloaded.
- FSM states: IDLE, EXPAND, DONE.
- Key acceptance: a key is accepted when Key_valid && Key_ready at an edge (cycle T). On that edge:
  - rk[0] is written with Cipher_key words 1-4; rk[1] is written with words 5-8.
  - The 256-bit window register is loaded with Cipher_key.
  - counter=2, state goes to EXPAND, Keys_valid goes to 0.
- EXPAND state:
  - Drives aes_key_expansion with Round_number=counter and Input_key=window.
  - Each edge writes rk[counter]=Output_key and sets window={window words 5-8, Output_key}.
  - counter increments each edge. When counter==14, that edge writes rk[14] and moves to DONE.
  - The state is exactly 13 cycles long. Busy=1 and Key_ready=0 throughout.
- DONE state:
  - Keys_valid=1 from cycle T+14 onward; Key_ready=1.
  - A new accepted key returns the FSM to EXPAND and drops Keys_valid on the same edge.
- Key_valid while Key_ready=0 is ignored; the source must hold the key.
- Counter width is 4 bits and covers values 2..14; it never wraps.
- Read port, 1-cycle latency: each edge sets Round_key to rk[Rk_index] if Keys_valid && Rk_index<=14, otherwise 0.
  - Rk_index=15 returns 0.
  - Reads during EXPAND return 0.
  - A read issued on the same edge that accepts a new key uses the pre-edge Keys_valid, so it returns the old key's data.
- Key_ready, Busy and Keys_valid are decoded from registered state only; there are no combinational input→output paths.

Decomposition:
- Add `AES_NUMBER_OF_ROUND_KEYS (15) and `AES_ROUND_KEY_INDEX_WIDTH (4) to aes_defines.svh.
- The state enum (IDLE, EXPAND, DONE) goes in the shared aes package for reuse by the cipher controller.
- Exactly one sub-module: the existing aes_key_expansion, instantiated once.
- Storage is an internal array of 15 x 128-bit registers.

Test Plan:
- FIPS-197 AES-256 key 000102…1e1f (words in defines order), Key_valid for 1 cycle → Busy high for 13 cycles; Keys_valid rises at T+14.
  - Rk_index=2 → Round_key=a573c29fa176c498a97fce93a572c09c next cycle.
  - Rk_index=14 → 24fc79ccbf0979e9371ac23c6d68de36.
- Same key, read indices 0 and 1 → 000102…0f and 101112…1f. Read index 15 → 0.
- Sweep Rk_index 14 down to 0 back-to-back → 15 consecutive correct keys matching the FIPS-197 C.3 k_sch values, each with 1-cycle latency.
- Hold Key_valid=1 with a second key during EXPAND → the key is not accepted until DONE.
  - The second key is accepted on the first DONE cycle, Keys_valid drops on that edge, and the new schedule completes 13 cycles later.
- Assert Rst at expansion cycle 5 → next cycle IDLE with Key_ready=1, Busy=0, Keys_valid=0, Round_key=0.
  - Reloading the FIPS key then produces the correct rk[14].
- Random keys (≥1000) checked against a reference model of the full schedule for all 15 indices.
